acc_cpu_port: RTL
=================

// Module: acc_cpu_port
// PURPOSE
// - CPU-side endpoint of the accelerator port: issues instructions to the accelerator and serves its regfile reads/writes.
// - Sits between CPU EX stage / integer regfile and the accelerator top (acc_instr/busy/ready, raddr/rdata/rvalid, waddr/wdata/wren, fwd_data/fwd_valid).
// - Keeps a per-register pending scoreboard so the CPU stalls on registers the accelerator still owes.
// PARAMETERS
// - DATA_WIDTH  32  regfile data width
// - INSTR_WIDTH 32  accelerator instruction width; rd field at [11:7]
// - NREGS       32  integer registers; address width AW = $clog2(NREGS)
// - IQ_DEPTH    2   instruction queue entries; power of 2, >=2
// PORTS
// clk_i            in   1            clock
// rst_ni           in   1            async reset, active low
// ex_instr_i       in   INSTR_WIDTH  instruction from CPU EX
// ex_rd_valid_i    in   1            instruction writes rd
// ex_valid_i       in   1            EX offers instruction
// ex_ready_o       out  1            queue not full
// acc_instr_o      out  INSTR_WIDTH  queue head to accelerator
// acc_instr_valid_o out 1            queue non-empty
// acc_ready_i      in   1            accelerator accepts head
// acc_busy_i       in   1            accelerator busy
// acc_raddr_i      in   AW           accelerator read address
// acc_rdata_o      out  DATA_WIDTH   read data
// acc_rvalid_o     out  1            read data valid
// acc_waddr_i/acc_wdata_i/acc_wren_i  in  AW/DATA_WIDTH/1  accelerator write
// cpu_waddr_i/cpu_wdata_i/cpu_wren_i  in  AW/DATA_WIDTH/1  CPU writeback request
// cpu_wb_stall_o   out  1            CPU writeback not taken this cycle
// rf_raddr_o/rf_rdata_i  out/in  AW/DATA_WIDTH  regfile read port (comb. read)
// rf_waddr_o/rf_wdata_o/rf_we_o  out  AW/DATA_WIDTH/1  regfile write port
// fwd_data_o/fwd_valid_o  out  DATA_WIDTH/1  forwarded CPU write data
// pending_o        out  NREGS        scoreboard; bit i = reg i owed by accelerator
// idle_o           out  1            queue empty, scoreboard clear, !acc_busy_i
// BEHAVIOUR
// - Reset: queue empty, scoreboard 0; all outputs 0 except ex_ready_o=1, idle_o=1 (if acc_busy_i=0).
// - Queue: push on ex_valid_i&&ex_ready_o, pop on acc_instr_valid_o&&acc_ready_i; simultaneous push+pop when full allowed only if ex_ready_o (full => ex_ready_o=0, no combinational pop->ready path). Pointers wrap mod IQ_DEPTH; head stable while valid&&!ready.
// - Scoreboard: on pop with rd!=0 and rd-valid stored bit, set pending[rd]. Accelerator write with acc_wren_i clears pending[acc_waddr_i]; set and clear same reg same cycle => set wins. Reg 0 never pending.
// - Read: rf_raddr_o=acc_raddr_i; acc_rdata_o/acc_rvalid_o registered (latency 1); rvalid=0 if pending[raddr] or a same-cycle write to raddr, else 1.
// - Write arbitration: acc_wren_i has priority (no back-pressure to accelerator). cpu_wren_i && acc_wren_i => cpu_wb_stall_o=1, CPU write dropped (CPU holds and retries). Writes to reg 0 suppressed (rf_we_o=0) but still clear nothing.
// - Accelerator write to a non-pending reg is legal, written normally.
// - Reset mid-operation: queue and scoreboard cleared, in-flight read response dropped.
// CONFIGURATION
// - ACC_CPU_PORT_FWD_EN defined: when CPU write is taken to reg R and R equals registered last acc_raddr_i, fwd_data_o=cpu_wdata_i, fwd_valid_o=1 same cycle; R=0 never forwarded.
// - Undefined: fwd_valid_o=0, fwd_data_o=0; accelerator re-reads.
// TESTING
// - Push 3 instrs (IQ_DEPTH=2), acc_ready_i=0 -> ex_ready_o=0 after 2; release ready -> pop in order, 1 per cycle.
// - Issue instr rd=5, then acc_raddr_i=5 -> acc_rvalid_o=0; acc_wren_i waddr=5 wdata=0xDEAD -> pending_o[5]=0, next read returns 0xDEAD, rvalid=1.
// - acc_wren_i and cpu_wren_i same cycle (regs 3,4) -> rf writes reg 3, cpu_wb_stall_o=1; next cycle reg 4 written.
// - FWD_EN: acc_raddr_i=7, CPU writes 7 with 0x1234 -> fwd_valid_o=1, fwd_data_o=0x1234; write to reg 0 -> no fwd, rf_we_o=0.
// - Pop with rd=9 and acc write to reg 9 same cycle -> pending_o[9]=1.
// - Assert rst_ni low with 2 queued, pending[5]=1 -> acc_instr_valid_o=0, pending_o=0, ex_ready_o=1 immediately.

Source files
------------

// File: rtl/acc_cpu_port_if.sv
// Accelerator-side bus of the CPU accelerator port: instruction issue, regfile read and write channels.
// The port (acc_cpu_port) uses the master modport; the accelerator uses the slave modport.
interface acc_cpu_port_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int AW          = 5
) ();
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   ready;
    logic                   busy;
    logic [AW-1:0]          raddr;
    logic [DATA_WIDTH-1:0]  rdata;
    logic                   rvalid;
    logic [AW-1:0]          waddr;
    logic [DATA_WIDTH-1:0]  wdata;
    logic                   wren;

    modport master (
        output instr, instr_valid, rdata, rvalid,
        input  ready, busy, raddr, waddr, wdata, wren
    );

    modport slave (
        input  instr, instr_valid, rdata, rvalid,
        output ready, busy, raddr, waddr, wdata, wren
    );
endinterface

// File: rtl/acc_cpu_port.sv
// CPU-side endpoint of the accelerator port: instruction queue, pending-register scoreboard, regfile arbitration.
// Optional macro ACC_CPU_PORT_FWD_EN forwards taken CPU writebacks that hit the accelerator's last read address.
module acc_cpu_port #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int NREGS       = 32,
    parameter int IQ_DEPTH    = 2,
    parameter int AW          = $clog2(NREGS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    acc_cpu_port_if.master         acc,
    input  logic [INSTR_WIDTH-1:0] ex_instr_i,
    input  logic                   ex_rd_valid_i,
    input  logic                   ex_valid_i,
    output logic                   ex_ready_o,
    input  logic [AW-1:0]          cpu_waddr_i,
    input  logic [DATA_WIDTH-1:0]  cpu_wdata_i,
    input  logic                   cpu_wren_i,
    output logic                   cpu_wb_stall_o,
    output logic [AW-1:0]          rf_raddr_o,
    input  logic [DATA_WIDTH-1:0]  rf_rdata_i,
    output logic [AW-1:0]          rf_waddr_o,
    output logic [DATA_WIDTH-1:0]  rf_wdata_o,
    output logic                   rf_we_o,
    output logic [DATA_WIDTH-1:0]  fwd_data_o,
    output logic                   fwd_valid_o,
    output logic [NREGS-1:0]       pending_o,
    output logic                   idle_o
);
    localparam int PW = $clog2(IQ_DEPTH);

    logic [INSTR_WIDTH-1:0] iq_instr [IQ_DEPTH];
    logic                   iq_rdv   [IQ_DEPTH];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            count;
    logic [NREGS-1:0]       pending_q, sb_set, sb_clr;
    logic [DATA_WIDTH-1:0]  rdata_q;
    logic                   rvalid_q;
    logic                   push, pop, q_valid, cpu_take, same_wr;
    logic [AW-1:0]          head_rd;

    // Readiness depends only on the registered count, so a pop never feeds back into ex_ready_o.
    assign ex_ready_o      = (count != (PW+1)'(IQ_DEPTH));
    assign q_valid         = (count != '0);
    assign push            = ex_valid_i && ex_ready_o;
    assign pop             = q_valid && acc.ready;
    assign acc.instr       = q_valid ? iq_instr[rd_ptr] : '0;
    assign acc.instr_valid = q_valid;
    assign head_rd         = AW'(iq_instr[rd_ptr][11:7]);

    always_comb begin
        sb_set = '0;
        sb_clr = '0;
        if (pop && iq_rdv[rd_ptr] && head_rd != '0) sb_set[head_rd] = 1'b1;
        if (acc.wren) sb_clr[acc.waddr] = 1'b1;
    end

    // Accelerator writes always win; a colliding CPU writeback is stalled and retried.
    assign cpu_take       = cpu_wren_i && !acc.wren;
    assign cpu_wb_stall_o = cpu_wren_i && acc.wren;
    assign rf_waddr_o     = acc.wren ? acc.waddr : cpu_waddr_i;
    assign rf_wdata_o     = acc.wren ? acc.wdata : cpu_wdata_i;
    assign rf_we_o        = (acc.wren || cpu_wren_i) && (rf_waddr_o != '0);
    assign rf_raddr_o     = acc.raddr;
    assign same_wr        = rf_we_o && (rf_waddr_o == acc.raddr);

    assign acc.rdata = rdata_q;
    assign acc.rvalid = rvalid_q;
    assign pending_o = pending_q;
    assign idle_o    = !q_valid && (pending_q == '0) && !acc.busy;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                iq_instr[i] <= '0;
                iq_rdv[i]   <= 1'b0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            pending_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            if (push) begin
                iq_instr[wr_ptr] <= ex_instr_i;
                iq_rdv[wr_ptr]   <= ex_rd_valid_i;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Set applied after clear so a same-cycle issue keeps the register owed.
            pending_q <= ((pending_q & ~sb_clr) | sb_set) & ~NREGS'(1);
            rdata_q   <= rf_rdata_i;
            rvalid_q  <= !(pending_q[acc.raddr] || same_wr);
        end
    end

`ifdef ACC_CPU_PORT_FWD_EN
    logic [AW-1:0] raddr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) raddr_q <= '0;
        else         raddr_q <= acc.raddr;
    end

    assign fwd_valid_o = cpu_take && (cpu_waddr_i != '0) && (cpu_waddr_i == raddr_q);
    assign fwd_data_o  = fwd_valid_o ? cpu_wdata_i : '0;
`else
    logic unused_fwd;
    assign unused_fwd  = cpu_take;
    assign fwd_valid_o = 1'b0;
    assign fwd_data_o  = '0;
`endif
endmodule
